pipe_ctrl: RTL and testbench

//   Hazard/stall/flush sequencer for the 5-stage Q1..Q5 pipeline.

---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/pipe_ctrl_if.sv | 38 +++
 rtl/pipe_ctrl_perf_ctr.sv | 21 ++
 rtl/pipe_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned TMO_W  = 16;
  localparam int unsigned PERF_W = 32;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    KILL_FETCH = 2'd2
  } pipe_ctrl_state_e;

  // One cycle's worth of pipeline-register and PC controls.
  typedef struct packed {
    logic pc_en;
    logic q1q2_en;
    logic q2q3_en;
    logic q3q4_en;
    logic q4q5_en;
    logic q1q2_flush;
    logic q2q3_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_FREEZE = '0;
  localparam pipe_ctrl_t CTRL_FLOW   = '{pc_en: 1'b1, q1q2_en: 1'b1, q2q3_en: 1'b1,
                                         q3q4_en: 1'b1, q4q5_en: 1'b1,
                                         q1q2_flush: 1'b0, q2q3_flush: 1'b0};

  function automatic logic src_hits(input logic use_src, input logic [REG_W-1:0] rs,
                                    input logic [REG_W-1:0] rd);
    return use_src & (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and pipeline controls between the core pipeline and pipe_ctrl.
interface pipe_ctrl_if import pipe_ctrl_pkg::*; ();

  logic [REG_W-1:0] i_q2_rs1;
  logic [REG_W-1:0] i_q2_rs2;
  logic             i_q2_use_rs1;
  logic             i_q2_use_rs2;
  logic             i_q3_is_load;
  logic [REG_W-1:0] i_q3_rd;
  logic             i_q3_redirect;
  logic             i_imem_ready;
  logic             i_dmem_req;
  logic             i_dmem_ready;

  logic             o_pc_en;
  logic             o_q1q2_en;
  logic             o_q2q3_en;
  logic             o_q3q4_en;
  logic             o_q4q5_en;
  logic             o_q1q2_flush;
  logic             o_q2q3_flush;
  logic             o_mem_timeout;

  modport master (
    output i_q2_rs1, i_q2_rs2, i_q2_use_rs1, i_q2_use_rs2, i_q3_is_load, i_q3_rd,
           i_q3_redirect, i_imem_ready, i_dmem_req, i_dmem_ready,
    input  o_pc_en, o_q1q2_en, o_q2q3_en, o_q3q4_en, o_q4q5_en,
           o_q1q2_flush, o_q2q3_flush, o_mem_timeout
  );

  modport slave (
    input  i_q2_rs1, i_q2_rs2, i_q2_use_rs1, i_q2_use_rs2, i_q3_is_load, i_q3_rd,
           i_q3_redirect, i_imem_ready, i_dmem_req, i_dmem_ready,
    output o_pc_en, o_q1q2_en, o_q2q3_en, o_q3q4_en, o_q4q5_en,
           o_q1q2_flush, o_q2q3_flush, o_mem_timeout
  );

endinterface

// File: rtl/pipe_ctrl_perf_ctr.sv
// Wrapping event counter with synchronous clear; used for pipeline performance stats.
module pipe_ctrl_perf_ctr import pipe_ctrl_pkg::*; (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [PERF_W-1:0] o_count
);

  logic [PERF_W-1:0] count_q;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      count_q <= '0;
    end else if (i_en) begin
      count_q <= count_q + PERF_W'(1);
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall/flush sequencer: data-memory wait, redirect, load-use, fetch wait.
// Optional PIPE_CTRL_PERF_EN adds stall-cycle and flush-event counters.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  pipe_ctrl_if.slave        bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] o_stall_cycles,
  output logic [PERF_W-1:0] o_flush_events
`endif
);

  localparam logic [TMO_W-1:0] CNT_SAT  = '1;
  // cnt_q holds the number of earlier stall cycles, so the pulse lands on the MEM_TIMEOUT-th one.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  pipe_ctrl_state_e state_q, state_d;
  logic             kill_pend_q, kill_pend_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;

  logic       mem_stall;
  logic       lu_haz;
  logic       timeout;
  pipe_ctrl_t ctrl;

  assign mem_stall = bus.i_dmem_req & ~bus.i_dmem_ready;
  assign lu_haz    = bus.i_q3_is_load & (bus.i_q3_rd != REG_W'(0)) &
                     (src_hits(bus.i_q2_use_rs1, bus.i_q2_rs1, bus.i_q3_rd) |
                      src_hits(bus.i_q2_use_rs2, bus.i_q2_rs2, bus.i_q3_rd));

  // Priority resolution and next-state decode.
  always_comb begin
    ctrl        = CTRL_FLOW;
    state_d     = state_q;
    kill_pend_d = kill_pend_q;
    cnt_d       = '0;
    timeout     = 1'b0;

    if (mem_stall) begin
      ctrl    = CTRL_FREEZE;
      state_d = MEM_WAIT;
      cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + TMO_W'(1);
      timeout = (cnt_q == TMO_LAST);
    end else if (state_q == KILL_FETCH) begin
      ctrl.q1q2_flush = 1'b1;
      if (bus.i_q3_redirect) begin
        ctrl.q2q3_flush = 1'b1;
      end else if (bus.i_imem_ready) begin
        kill_pend_d = 1'b0;
        state_d     = RUN;
      end
    end else begin
      // RUN, or the MEM_WAIT cycle in which the data access completes.
      if (bus.i_q3_redirect) begin
        ctrl.q1q2_flush = 1'b1;
        ctrl.q2q3_flush = 1'b1;
        if (!bus.i_imem_ready) begin
          kill_pend_d = 1'b1;
        end
      end else if (lu_haz) begin
        ctrl.pc_en      = 1'b0;
        ctrl.q1q2_en    = 1'b0;
        ctrl.q2q3_flush = 1'b1;
      end else if (!bus.i_imem_ready) begin
        ctrl.pc_en      = 1'b0;
        ctrl.q1q2_flush = 1'b1;
      end
      state_d = kill_pend_d ? KILL_FETCH : RUN;
    end

    if (i_rst) begin
      ctrl    = CTRL_FREEZE;
      timeout = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= RUN;
      kill_pend_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      kill_pend_q <= kill_pend_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.o_pc_en       = ctrl.pc_en;
  assign bus.o_q1q2_en     = ctrl.q1q2_en;
  assign bus.o_q2q3_en     = ctrl.q2q3_en;
  assign bus.o_q3q4_en     = ctrl.q3q4_en;
  assign bus.o_q4q5_en     = ctrl.q4q5_en;
  assign bus.o_q1q2_flush  = ctrl.q1q2_flush;
  assign bus.o_q2q3_flush  = ctrl.q2q3_flush;
  assign bus.o_mem_timeout = timeout;

`ifdef PIPE_CTRL_PERF_EN
  logic stall_evt;
  logic flush_evt;

  assign stall_evt = ~ctrl.pc_en;
  assign flush_evt = ctrl.q1q2_flush | ctrl.q2q3_flush;

  pipe_ctrl_perf_ctr u_stall_ctr (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_en    (stall_evt),
    .o_count (o_stall_cycles)
  );

  pipe_ctrl_perf_ctr u_flush_ctr (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_en    (flush_evt),
    .o_count (o_flush_events)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural model of the hazard rules.
module tb_pipe_ctrl;

  localparam int unsigned TMO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  pipe_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .o_stall_cycles (stall_cnt),
    .o_flush_events (flush_cnt)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc_no = 0;

  // Model state: a wrong-path fetch is outstanding; length of the current data-memory stall run.
  bit          m_kill = 1'b0;
  bit          m_prev_stall = 1'b0;
  int unsigned m_run = 0;
  logic [31:0] m_stall_cnt = '0;
  logic [31:0] m_flush_cnt = '0;

  // Vector order: pc_en q1q2_en q2q3_en q3q4_en q4q5_en q1q2_flush q2q3_flush mem_timeout
  function automatic logic [7:0] dut_vec();
    return {bus.o_pc_en, bus.o_q1q2_en, bus.o_q2q3_en, bus.o_q3q4_en, bus.o_q4q5_en,
            bus.o_q1q2_flush, bus.o_q2q3_flush, bus.o_mem_timeout};
  endfunction

  always @(negedge clk) begin
    logic [7:0] exp_v;
    logic [7:0] act_v;
    bit stall;
    bit lu;
    bit kill_mode;
    cyc_no++;
    stall = bus.i_dmem_req && !bus.i_dmem_ready;
    lu = bus.i_q3_is_load && (bus.i_q3_rd != 5'd0) &&
         ((bus.i_q2_use_rs1 && bus.i_q2_rs1 == bus.i_q3_rd) ||
          (bus.i_q2_use_rs2 && bus.i_q2_rs2 == bus.i_q3_rd));
    kill_mode = m_kill && !m_prev_stall;

    if (rst)                     exp_v = 8'h00;
    else if (stall)              exp_v = (m_run + 1 == TMO) ? 8'h01 : 8'h00;
    else if (kill_mode)          exp_v = bus.i_q3_redirect ? 8'hFE : 8'hFC;
    else if (bus.i_q3_redirect)  exp_v = 8'hFE;
    else if (lu)                 exp_v = 8'h3A;
    else if (!bus.i_imem_ready)  exp_v = 8'h7C;
    else                         exp_v = 8'hF8;

    act_v = dut_vec();
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL model_ctrl cycle=%0d actual=%b required=%b", cyc_no, act_v, exp_v);
    end

`ifdef PIPE_CTRL_PERF_EN
    n_cmp++;
    if (stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) begin
      n_fail++;
      $display("FAIL perf_counters cycle=%0d actual=%0d/%0d required=%0d/%0d",
               cyc_no, stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
    end
    if (rst) begin
      m_stall_cnt = '0;
      m_flush_cnt = '0;
    end else begin
      m_stall_cnt = m_stall_cnt + 32'(!exp_v[7]);
      m_flush_cnt = m_flush_cnt + 32'(exp_v[2] | exp_v[1]);
    end
`endif

    if (rst) begin
      m_kill       = 1'b0;
      m_prev_stall = 1'b0;
      m_run        = 0;
    end else begin
      if (!stall) begin
        if (kill_mode && !bus.i_q3_redirect && bus.i_imem_ready) m_kill = 1'b0;
        else if (!kill_mode && bus.i_q3_redirect && !bus.i_imem_ready) m_kill = 1'b1;
      end
      m_prev_stall = stall;
      m_run        = stall ? m_run + 1 : 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_q2_rs1      = 5'd0;
    bus.i_q2_rs2      = 5'd0;
    bus.i_q2_use_rs1  = 1'b0;
    bus.i_q2_use_rs2  = 1'b0;
    bus.i_q3_is_load  = 1'b0;
    bus.i_q3_rd       = 5'd0;
    bus.i_q3_redirect = 1'b0;
    bus.i_imem_ready  = 1'b1;
    bus.i_dmem_req    = 1'b0;
    bus.i_dmem_ready  = 1'b1;
  endtask

  task automatic lit(input string name, input logic [7:0] req);
    logic [7:0] act_v;
    #2;
    act_v = dut_vec();
    n_cmp++;
    if (act_v !== req) begin
      n_fail++;
      $display("FAIL %s actual=%b required=%b", name, act_v, req);
    end
  endtask

  task automatic load_use(input logic [4:0] r);
    bus.i_q3_is_load = 1'b1;
    bus.i_q3_rd      = r;
    bus.i_q2_rs1     = r;
    bus.i_q2_use_rs1 = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cyc();  lit("reset_outputs", 8'h00);
    cyc();  rst = 1'b0;  lit("idle_run", 8'hF8);

    cyc();  load_use(5'd5);  lit("t1_lu_bubble", 8'h3A);
    cyc();  idle();  lit("t1_release", 8'hF8);

    cyc();  load_use(5'd0);  lit("t2_x0_no_stall", 8'hF8);
    cyc();  idle();  bus.i_q3_is_load = 1'b1;  bus.i_q3_rd = 5'd7;
            bus.i_q2_rs2 = 5'd7;  bus.i_q2_use_rs2 = 1'b1;  lit("lu_rs2", 8'h3A);
    cyc();  bus.i_q2_use_rs2 = 1'b0;  bus.i_q2_rs1 = 5'd7;  lit("lu_unused_src", 8'hF8);

    for (int i = 0; i < 3; i++) begin
      cyc();  idle();  bus.i_dmem_req = 1'b1;  bus.i_dmem_ready = 1'b0;  lit("t3_mem_wait", 8'h00);
    end
    cyc();  bus.i_dmem_ready = 1'b1;  lit("t3_mem_done", 8'hF8);

    cyc();  idle();  bus.i_q3_redirect = 1'b1;  bus.i_imem_ready = 1'b0;  lit("t4_redirect", 8'hFE);
    cyc();  bus.i_q3_redirect = 1'b0;  lit("t4_kill_hold", 8'hFC);
    cyc();  lit("t4_kill_hold2", 8'hFC);
    cyc();  bus.i_imem_ready = 1'b1;  lit("t4_kill_last", 8'hFC);
    cyc();  idle();  lit("t4_back_run", 8'hF8);

    cyc();  idle();  bus.i_q3_redirect = 1'b1;  load_use(5'd9);
            bus.i_dmem_req = 1'b1;  bus.i_dmem_ready = 1'b0;  lit("t5_freeze_only", 8'h00);
    cyc();  bus.i_dmem_ready = 1'b1;  lit("t5_redirect_wins", 8'hFE);
    cyc();  idle();  lit("t5_after", 8'hF8);

    for (int i = 0; i < 6; i++) begin
      cyc();  idle();  bus.i_dmem_req = 1'b1;  bus.i_dmem_ready = 1'b0;
      lit("t6_timeout", (i == 3) ? 8'h01 : 8'h00);
    end
    cyc();  rst = 1'b1;  lit("t6_reset_mid_wait", 8'h00);
    cyc();  rst = 1'b0;  idle();  lit("t6_run_after_reset", 8'hF8);

    cyc();  idle();  bus.i_q3_redirect = 1'b1;  bus.i_imem_ready = 1'b0;  lit("kill_arm", 8'hFE);
    cyc();  idle();  bus.i_imem_ready = 1'b0;  bus.i_dmem_req = 1'b1;  bus.i_dmem_ready = 1'b0;
            lit("kill_then_stall", 8'h00);
    cyc();  rst = 1'b1;  lit("kill_reset", 8'h00);
    cyc();  rst = 1'b0;  idle();  bus.i_imem_ready = 1'b0;  lit("kill_dropped", 8'h7C);

    cyc();  idle();  bus.i_q3_redirect = 1'b1;  bus.i_imem_ready = 1'b0;  lit("kill_arm2", 8'hFE);
    cyc();  idle();  bus.i_imem_ready = 1'b0;  bus.i_dmem_req = 1'b1;  bus.i_dmem_ready = 1'b0;
            lit("kill_stall2", 8'h00);
    cyc();  bus.i_dmem_ready = 1'b1;  lit("wait_exit_as_run", 8'h7C);
    cyc();  idle();  bus.i_imem_ready = 1'b0;  lit("kill_resumed", 8'hFC);
    cyc();  idle();  lit("kill_final", 8'hFC);
    cyc();  idle();  lit("run_again", 8'hF8);

    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst               = ($urandom_range(63) == 0);
      bus.i_q2_rs1      = 5'($urandom_range(3));
      bus.i_q2_rs2      = 5'($urandom_range(3));
      bus.i_q2_use_rs1  = 1'($urandom_range(1));
      bus.i_q2_use_rs2  = 1'($urandom_range(1));
      bus.i_q3_is_load  = ($urandom_range(2) == 0);
      bus.i_q3_rd       = 5'($urandom_range(3));
      bus.i_q3_redirect = ($urandom_range(7) == 0);
      bus.i_imem_ready  = ($urandom_range(3) != 0);
      bus.i_dmem_req    = ($urandom_range(2) == 0);
      bus.i_dmem_ready  = ($urandom_range(i[8] ? 7 : 1) == 0);
    end

    cyc();
    idle();
    rst = 1'b0;
    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
